stack_engine: RTL and testbench
===============================

STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 SHALL have parameters (name, default, meaning): STACK_BASE, 19'h7FFFF, first free stack word (grows downward); STACK_DEPTH, 64, max entries; DW, 19, data/address width.
REQ-002 SHALL have ports (name, direction, width, meaning): clk in 1 clock; rst in 1 reset. One clock; reset is synchronous and active-high.
REQ-003 SHALL have sp_sel in 2: 0 none, 1 push (CALL), 2 pop (RET), 3 reserved. It comes from the control unit.
REQ-004 SHALL have ret_addr in DW, the return address to push.
REQ-005 SHALL have mem_req out 1, mem_we out 1, mem_addr out DW, mem_wdata out DW, mem_rdata in DW and mem_ack in 1 for the data-memory handshake.
REQ-006 SHALL have stall out 1; pc_target out DW; pc_target_valid out 1 (1-cycle pulse); sp out DW; depth out 7; fault out 1.

Function
REQ-007 SHALL implement the FSM states IDLE, PUSH, POP and FAULT.
REQ-008 In IDLE, a request (sp_sel of 1 or 2) SHALL drive stall high combinationally in the same cycle. Next state is PUSH or POP, and ret_addr is captured on that edge.
REQ-009 sp_sel=3 or 0 in IDLE SHALL be ignored, with no state change and stall=0.
REQ-010 In PUSH, the block SHALL hold mem_req=1, mem_we=1, mem_addr=sp and mem_wdata=captured ret_addr stable until mem_ack.
REQ-011 On mem_ack in PUSH, on the same edge: sp <= sp-1, depth <= depth+1, return to IDLE. stall SHALL be low in the following cycle.
REQ-012 In POP, the block SHALL hold mem_req=1, mem_we=0, mem_addr=sp+1 until mem_ack.
REQ-013 On mem_ack in POP: pc_target <= mem_rdata, pc_target_valid=1 for exactly the next cycle, sp <= sp+1, depth <= depth-1, return to IDLE.
REQ-014 stall SHALL be 1 throughout PUSH and POP, including the mem_ack cycle.
REQ-015 sp_sel SHALL be ignored outside IDLE. No request queuing.
REQ-016 Minimum latency is request cycle + 1 cycle when mem_ack arrives in the first PUSH/POP cycle. No upper bound (waits indefinitely for ack).
REQ-017 sp arithmetic SHALL be modulo 2^DW. depth SHALL never exceed STACK_DEPTH when the guard is enabled.
REQ-018 mem_we and mem_wdata SHALL be 0 whenever mem_req=0.

Reset
REQ-019 On rst: state=IDLE, sp=STACK_BASE, depth=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, pc_target=0, pc_target_valid=0, fault=0, stall=0.
REQ-020 rst during PUSH/POP SHALL abort: mem_req=0 from the next cycle, and no sp/depth update even if mem_ack coincides.

Configuration
REQ-021 Macro STACK_GUARD_EN: when defined, a push with depth==STACK_DEPTH or a pop with depth==0 SHALL enter FAULT with no memory access.
REQ-022 FAULT is sticky until rst, with fault=1, stall=1 and all requests ignored.
REQ-023 Without STACK_GUARD_EN: no FAULT state and fault tied 0. A push at full or pop at empty proceeds normally, with sp wrapping modulo 2^DW and depth wrapping modulo 128.

Structure
REQ-024 A shared package SHALL hold the sp_sel encodings (SP_NONE=0, SP_PUSH=1, SP_POP=2), the FSM state encoding, and the STACK_BASE/STACK_DEPTH defaults.
REQ-025 The block SHALL be a single module with no sub-module. The memory handshake is inline in the FSM.

Verification
REQ-026 Push: rst, then sp_sel=1, ret_addr=19'h00123, mem_ack on the 2nd PUSH cycle -> write to addr 7FFFF with data 00123; sp=7FFFE, depth=1; stall high for 3 cycles.
REQ-027 Push then pop: after REQ-026, sp_sel=2 with mem_rdata=00123 and immediate ack -> read addr 7FFFF; pc_target=00123 with valid pulsed 1 cycle; sp=7FFFF, depth=0.
REQ-028 Nested calls: 3 pushes of 10, 20, 30 then 3 pops (memory model) -> pc_target sequence 30, 20, 10, ending at depth 0.
REQ-029 Guard: with STACK_GUARD_EN, a pop at depth 0 -> fault=1 and stall=1 next cycle, no mem_req. Same test without the macro -> read of addr 0 (wrap), sp=0.
REQ-030 Abort: rst asserted in the mem_ack cycle of a push -> sp=7FFFF, depth=0, mem_req=0 next cycle.
REQ-031 Overflow: 64 pushes then a 65th with guard enabled -> fault=1, depth=64, 64 memory writes total.

Source files
------------

// File: rtl/stack_engine_pkg.sv
// Shared encodings for the call/return stack engine: sp_sel codes, FSM states
// and the default stack placement.
package stack_engine_pkg;

    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_PUSH = 2'd1;
    localparam logic [1:0] SP_POP  = 2'd2;
    localparam logic [1:0] SP_RSVD = 2'd3;

    localparam logic [18:0] DEF_STACK_BASE  = 19'h7FFFF;
    localparam int          DEF_STACK_DEPTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PUSH  = 2'd1,
        POP   = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/stack_engine.sv
// Hardware return-address stack living in data memory, driven by CALL/RET.
// Optional STACK_GUARD_EN build macro traps overflow/underflow into a sticky FAULT.
module stack_engine
    import stack_engine_pkg::*;
#(
    parameter int          DW          = 19,
    parameter logic [DW-1:0] STACK_BASE = DW'(DEF_STACK_BASE),
    parameter int          STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    sp_sel,
    input  logic [DW-1:0] ret_addr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          stall,
    output logic [DW-1:0] pc_target,
    output logic          pc_target_valid,
    output logic [DW-1:0] sp,
    output logic [6:0]    depth,
    output logic          fault
);

    state_t        state_reg, state_next;
    logic [DW-1:0] sp_reg, sp_next;
    logic [6:0]    depth_reg, depth_next;
    logic [DW-1:0] ret_reg, ret_next;
    logic [DW-1:0] pc_target_reg, pc_target_next;
    logic          pc_valid_reg, pc_valid_next;
    logic          stall_c;
    logic          push_blocked, pop_blocked;

`ifdef STACK_GUARD_EN
    assign push_blocked = (depth_reg == 7'(STACK_DEPTH));
    assign pop_blocked  = (depth_reg == 7'd0);
`else
    assign push_blocked = 1'b0;
    assign pop_blocked  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            sp_reg        <= STACK_BASE;
            depth_reg     <= '0;
            ret_reg       <= '0;
            pc_target_reg <= '0;
            pc_valid_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sp_reg        <= sp_next;
            depth_reg     <= depth_next;
            ret_reg       <= ret_next;
            pc_target_reg <= pc_target_next;
            pc_valid_reg  <= pc_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sp_next        = sp_reg;
        depth_next     = depth_reg;
        ret_next       = ret_reg;
        pc_target_next = pc_target_reg;
        pc_valid_next  = 1'b0;
        stall_c        = 1'b0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (state_reg)
            IDLE: begin
                // Reserved and none codes fall through with no effect.
                if (sp_sel == SP_PUSH) begin
                    stall_c    = 1'b1;
                    ret_next   = ret_addr;
                    state_next = push_blocked ? FAULT : PUSH;
                end else if (sp_sel == SP_POP) begin
                    stall_c    = 1'b1;
                    state_next = pop_blocked ? FAULT : POP;
                end
            end
            PUSH: begin
                stall_c   = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp_reg;
                mem_wdata = ret_reg;
                if (mem_ack) begin
                    sp_next    = sp_reg - DW'(1);
                    depth_next = depth_reg + 7'd1;
                    state_next = IDLE;
                end
            end
            POP: begin
                stall_c  = 1'b1;
                mem_req  = 1'b1;
                mem_addr = sp_reg + DW'(1);
                if (mem_ack) begin
                    pc_target_next = mem_rdata;
                    pc_valid_next  = 1'b1;
                    sp_next        = sp_reg + DW'(1);
                    depth_next     = depth_reg - 7'd1;
                    state_next     = IDLE;
                end
            end
`ifdef STACK_GUARD_EN
            FAULT: begin
                stall_c = 1'b1;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is held so the pipeline sees a clean start.
    assign stall           = stall_c && !rst;
    assign pc_target       = pc_target_reg;
    assign pc_target_valid = pc_valid_reg;
    assign sp              = sp_reg;
    assign depth           = depth_reg;
`ifdef STACK_GUARD_EN
    assign fault = (state_reg == FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_stack_engine.sv
// Directed bench for stack_engine: push/pop handshakes, nesting, abort, and
// underflow/overflow behaviour for whichever STACK_GUARD_EN build is compiled.
module tb_stack_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  sp_sel;
    logic [18:0] ret_addr;
    logic        mem_req, mem_we;
    logic [18:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [18:0] pc_target;
    logic        pc_target_valid;
    logic [18:0] sp;
    logic [6:0]  depth;
    logic        fault;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    logic [18:0] mem_model [logic [18:0]];
    logic [18:0] popped;

    stack_engine dut (
        .clk(clk), .rst(rst), .sp_sel(sp_sel), .ret_addr(ret_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .pc_target(pc_target), .pc_target_valid(pc_target_valid),
        .sp(sp), .depth(depth), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sp_sel = 2'd0; mem_ack = 1'b0; mem_rdata = '0; ret_addr = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Push with ack in the first PUSH cycle; the bench memory records the write.
    task automatic do_push(input logic [18:0] val);
        @(negedge clk);
        sp_sel = 2'd1; ret_addr = val;
        @(posedge clk);
        @(negedge clk);
        sp_sel = 2'd0;
        if (mem_req && mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            writes++;
        end
        mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic do_pop(output logic [18:0] val);
        @(negedge clk);
        sp_sel = 2'd2;
        @(posedge clk);
        @(negedge clk);
        sp_sel = 2'd0;
        mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 19'h0;
        mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        val = pc_target;
        check("pop_valid", 32'(pc_target_valid), 32'd1);
    endtask

    initial begin
        rst = 1'b1; sp_sel = 2'd0; ret_addr = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state, with a request pending to prove stall is held low.
        @(negedge clk);
        sp_sel = 2'd1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_sp", 32'(sp), 32'h7FFFF);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_pc_target", 32'(pc_target), 32'd0);
        check("rst_valid", 32'(pc_target_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        sp_sel = 2'd0;
        rst = 1'b0;

        // Reserved code is ignored.
        @(negedge clk);
        sp_sel = 2'd3;
        #1;
        check("rsvd_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        sp_sel = 2'd0;
        check("rsvd_mem_req", 32'(mem_req), 32'd0);

        // Push 00123 with ack delayed to the second PUSH cycle.
        do_reset();
        sp_sel = 2'd1; ret_addr = 19'h00123;
        #1;
        check("push_req_stall", 32'(stall), 32'd1);
        check("push_req_memreq", 32'(mem_req), 32'd0);
        @(posedge clk);
        @(negedge clk);
        sp_sel = 2'd0; ret_addr = 19'h0;
        check("push1_stall", 32'(stall), 32'd1);
        check("push1_req", 32'(mem_req), 32'd1);
        check("push1_we", 32'(mem_we), 32'd1);
        check("push1_addr", 32'(mem_addr), 32'h7FFFF);
        check("push1_wdata", 32'(mem_wdata), 32'h00123);
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b1;
        check("push2_stall", 32'(stall), 32'd1);
        check("push2_wdata", 32'(mem_wdata), 32'h00123);
        check("push2_sp_hold", 32'(sp), 32'h7FFFF);
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        check("push_done_stall", 32'(stall), 32'd0);
        check("push_done_sp", 32'(sp), 32'h7FFFE);
        check("push_done_depth", 32'(depth), 32'd1);
        check("push_done_req", 32'(mem_req), 32'd0);
        check("push_done_we", 32'(mem_we), 32'd0);
        check("push_done_wdata", 32'(mem_wdata), 32'd0);

        // Pop with immediate ack returns 00123.
        sp_sel = 2'd2; mem_rdata = 19'h00123;
        #1;
        check("pop_req_stall", 32'(stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        sp_sel = 2'd0; mem_ack = 1'b1;
        check("pop_req", 32'(mem_req), 32'd1);
        check("pop_we", 32'(mem_we), 32'd0);
        check("pop_addr", 32'(mem_addr), 32'h7FFFF);
        check("pop_ack_stall", 32'(stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 19'h0;
        check("pop_target", 32'(pc_target), 32'h00123);
        check("pop_valid1", 32'(pc_target_valid), 32'd1);
        check("pop_sp", 32'(sp), 32'h7FFFF);
        check("pop_depth", 32'(depth), 32'd0);
        check("pop_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("pop_valid_pulse", 32'(pc_target_valid), 32'd0);
        check("pop_target_hold", 32'(pc_target), 32'h00123);

        // Nested calls unwind in reverse order.
        do_reset();
        mem_model.delete();
        do_push(19'd10);
        do_push(19'd20);
        do_push(19'd30);
        check("nest_depth3", 32'(depth), 32'd3);
        check("nest_sp3", 32'(sp), 32'h7FFFC);
        do_pop(popped);
        check("nest_pop30", 32'(popped), 32'd30);
        do_pop(popped);
        check("nest_pop20", 32'(popped), 32'd20);
        do_pop(popped);
        check("nest_pop10", 32'(popped), 32'd10);
        check("nest_depth0", 32'(depth), 32'd0);
        check("nest_sp0", 32'(sp), 32'h7FFFF);

        // Reset coinciding with the push ack aborts the update.
        do_reset();
        sp_sel = 2'd1; ret_addr = 19'h00456;
        @(posedge clk);
        @(negedge clk);
        sp_sel = 2'd0; mem_ack = 1'b1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b0;
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_sp", 32'(sp), 32'h7FFFF);
        check("abort_depth", 32'(depth), 32'd0);

        // Pop at empty.
        do_reset();
        sp_sel = 2'd2;
        @(posedge clk);
        @(negedge clk);
        sp_sel = 2'd0;
`ifdef STACK_GUARD_EN
        check("uflow_fault", 32'(fault), 32'd1);
        check("uflow_stall", 32'(stall), 32'd1);
        check("uflow_req", 32'(mem_req), 32'd0);
        sp_sel = 2'd1; mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sp_sel = 2'd0; mem_ack = 1'b0;
        check("uflow_sticky", 32'(fault), 32'd1);
        check("uflow_sticky_req", 32'(mem_req), 32'd0);
        check("uflow_sp", 32'(sp), 32'h7FFFF);
`else
        check("uflow_req", 32'(mem_req), 32'd1);
        check("uflow_addr", 32'(mem_addr), 32'd0);
        mem_rdata = 19'h00055; mem_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 19'h0;
        check("uflow_sp", 32'(sp), 32'd0);
        check("uflow_depth", 32'(depth), 32'd127);
        check("uflow_target", 32'(pc_target), 32'h00055);
        check("uflow_fault", 32'(fault), 32'd0);
`endif

        // 64 pushes, then one more.
        do_reset();
        writes = 0;
        for (int i = 0; i < 64; i++) do_push(19'(i + 100));
        check("full_depth", 32'(depth), 32'd64);
        check("full_writes", 32'(writes), 32'd64);
        do_push(19'h00777);
`ifdef STACK_GUARD_EN
        check("oflow_fault", 32'(fault), 32'd1);
        check("oflow_depth", 32'(depth), 32'd64);
        check("oflow_writes", 32'(writes), 32'd64);
`else
        check("oflow_fault", 32'(fault), 32'd0);
        check("oflow_depth", 32'(depth), 32'd65);
        check("oflow_writes", 32'(writes), 32'd65);
        check("oflow_sp", 32'(sp), 32'h7FFBE);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
